// File: rtl/cpa_seg_pipe.sv
// -----------------------------------------------------------------------------
// cpa_seg_pipe
//   Pipelined, segmented carry-propagate adder computing A + B + Cin over WIDTH
//   bits. Each pipeline stage ripples one SEG_WIDTH-bit segment through a chain
//   of full-adder cells and registers the segment sum and its carry-out. Upper,
//   not-yet-added A/B segments travel alongside in skew registers, and lower,
//   already-resolved sum segments are forwarded unchanged. The result emerges
//   NUM_SEG advancing cycles after acceptance.
//
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      in_a/in_b/in_cin hold a valid operation
//   in_ready   out  1      operation accepted this cycle when in_valid is high
//   in_a       in   WIDTH  operand A (carry-save sum vector)
//   in_b       in   WIDTH  operand B (carry-save carry vector, pre-shifted)
//   in_cin     in   1      carry into bit 0
//   out_valid  out  1      out_sum/out_cout hold a valid result
//   out_ready  in   1      consumer accepts the result this cycle
//   out_sum    out  WIDTH  (A + B + Cin) mod 2^WIDTH
//   out_cout   out  1      carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module cpa_seg_pipe #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned SEG_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int unsigned NUM_SEG = WIDTH / SEG_WIDTH;

    // Per-stage pipeline registers
    logic             r_v   [NUM_SEG];
    logic             r_c   [NUM_SEG];
    logic [WIDTH-1:0] r_a   [NUM_SEG];
    logic [WIDTH-1:0] r_b   [NUM_SEG];
    logic [WIDTH-1:0] r_sum [NUM_SEG];

    // Per-stage inputs (from the previous stage, or the ports for stage 0)
    logic             w_src_v   [NUM_SEG];
    logic             w_src_c   [NUM_SEG];
    logic [WIDTH-1:0] w_src_a   [NUM_SEG];
    logic [WIDTH-1:0] w_src_b   [NUM_SEG];
    logic [WIDTH-1:0] w_src_sum [NUM_SEG];

    // Per-stage results to be registered
    logic [WIDTH-1:0] w_next_sum [NUM_SEG];
    logic             w_next_c   [NUM_SEG];

    logic w_adv;
    logic w_carry;
    logic w_bit_a;
    logic w_bit_b;

    // The whole pipe moves together: a stalled output freezes every stage, so
    // no bubbles are ever squeezed out.
    always_comb begin
        w_adv   = !r_v[NUM_SEG-1] || out_ready;
        w_carry = 1'b0;
        w_bit_a = 1'b0;
        w_bit_b = 1'b0;
        for (int unsigned k = 0; k < NUM_SEG; k++) begin
            if (k == 0) begin
                w_src_v[k]   = in_valid;
                w_src_c[k]   = in_cin;
                w_src_a[k]   = in_a;
                w_src_b[k]   = in_b;
                w_src_sum[k] = '0;
            end else begin
                w_src_v[k]   = r_v[k-1];
                w_src_c[k]   = r_c[k-1];
                w_src_a[k]   = r_a[k-1];
                w_src_b[k]   = r_b[k-1];
                w_src_sum[k] = r_sum[k-1];
            end

            // Ripple of full-adder cells across segment k; all other bits of
            // the sum vector pass through untouched.
            w_next_sum[k] = w_src_sum[k];
            w_carry       = w_src_c[k];
            for (int unsigned j = 0; j < SEG_WIDTH; j++) begin
                w_bit_a = w_src_a[k][k*SEG_WIDTH + j];
                w_bit_b = w_src_b[k][k*SEG_WIDTH + j];
                w_next_sum[k][k*SEG_WIDTH + j] = w_bit_a ^ w_bit_b ^ w_carry;
                w_carry = (w_bit_a & w_bit_b) | (w_carry & (w_bit_a ^ w_bit_b));
            end
            w_next_c[k] = w_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_SEG; k++) begin
                r_v[k]   <= 1'b0;
                r_c[k]   <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
        end else if (w_adv) begin
            for (int unsigned k = 0; k < NUM_SEG; k++) begin
                r_v[k]   <= w_src_v[k];
                r_c[k]   <= w_next_c[k];
                r_a[k]   <= w_src_a[k];
                r_b[k]   <= w_src_b[k];
                r_sum[k] <= w_next_sum[k];
            end
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_v[NUM_SEG-1];
    assign out_sum   = r_sum[NUM_SEG-1];
    assign out_cout  = r_c[NUM_SEG-1];

endmodule
